stepper_drive: RTL and testbench

- Parametrised stepper-motor phase driver. Successor to the fixed 4-coil speed/direction car drive.
- Adds in one block: configurable phase count, speed-code width and divider base; wave, full and half step modes; a finite step count with done pulse; abort; holding torque.
- Sits between the board switch/button layer and the coil outputs or LEDs. Contains its own tick divider.

---
 rtl/stepper_drive.sv | 151 +++++++++++++++
 tb/tb_stepper_drive.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_drive.sv
// Parametrised stepper-motor phase driver: wave/full/half stepping with an
// internal step-rate divider, finite or continuous moves, abort and holding torque.
module stepper_drive #(
  parameter int PHASES   = 4,
  parameter int SPD_W    = 2,
  parameter int BASE_DIV = 1000000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clockwise,
  input  logic [SPD_W-1:0] speed,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] steps,
  output logic [PHASES-1:0] coils,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam int NPOS       = 2 * PHASES;
  localparam int POS_W      = $clog2(NPOS);
  localparam int MAX_PERIOD = BASE_DIV * (2 ** SPD_W);
  localparam int DIV_W      = $clog2(MAX_PERIOD);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {M_WAVE, M_FULL, M_HALF} mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [PHASES-1:0] coils_q, coils_d;
  logic              cont_q, cont_d;
  logic              energised_q, energised_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  period_m1;
  logic              tick;

  // Even index energises one coil; odd index energises the two neighbours.
  function automatic logic [PHASES-1:0] pattern(input logic [POS_W-1:0] p);
    logic [PHASES-1:0] r;
    int lo, hi;
    lo = int'(p) / 2;
    hi = ((int'(p) + 1) / 2) % PHASES;
    for (int i = 0; i < PHASES; i++) begin
      r[i] = (i == lo) || (p[0] && (i == hi));
    end
    return r;
  endfunction

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                input logic cw, input logic half);
    int stride, nxt;
    stride = half ? 1 : 2;
    nxt    = cw ? int'(p) + stride : int'(p) + NPOS - stride;
    return POS_W'(nxt % NPOS);
  endfunction

  // Speed is live, so a shorter period below the current count ticks at once.
  assign period_m1 = DIV_W'(BASE_DIV * (int'(speed) + 1) - 1);
  assign tick      = (div_q >= period_m1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    mode_d      = mode_q;
    pos_d       = pos_q;
    div_d       = div_q;
    remaining_d = remaining_q;
    cont_d      = cont_q;
    energised_d = energised_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          unique case (mode)
            2'b01:   mode_d = M_FULL;
            2'b10:   mode_d = M_HALF;
            default: mode_d = M_WAVE;
          endcase
          remaining_d = steps;
          cont_d      = (steps == '0);
          div_d       = '0;
          energised_d = 1'b1;
          state_d     = S_RUN;
          unique case (mode_d)
            M_WAVE:  pos_d = {pos_q[POS_W-1:1], 1'b0};
            M_FULL:  pos_d = {pos_q[POS_W-1:1], 1'b1};
            default: pos_d = pos_q;
          endcase
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          div_d = '0;
          pos_d = step_pos(pos_q, clockwise, mode_q == M_HALF);
          if (!cont_q) begin
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    coils_d = energised_d ? pattern(pos_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_WAVE;
      pos_q       <= '0;
      div_q       <= '0;
      remaining_q <= '0;
      coils_q     <= '0;
      cont_q      <= 1'b0;
      energised_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      div_q       <= div_d;
      remaining_q <= remaining_d;
      coils_q     <= coils_d;
      cont_q      <= cont_d;
      energised_q <= energised_d;
      done_q      <= done_d;
    end
  end

  assign coils     = coils_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_stepper_drive.sv
// Scoreboard bench for stepper_drive: a cycle-level reference model queues each
// expected output change; a monitor compares whenever the DUT outputs change.
module tb_stepper_drive;
  localparam int PHASES   = 4;
  localparam int SPD_W    = 2;
  localparam int BASE_DIV = 4;
  localparam int CNT_W    = 16;
  localparam int NPOS     = 2 * PHASES;

  logic        clk = 1'b0;
  logic        reset, start, stop, clockwise;
  logic [1:0]  speed, mode;
  logic [15:0] steps;
  logic [3:0]  coils;
  logic        busy, done;
  logic [15:0] remaining;

  stepper_drive #(.PHASES(PHASES), .SPD_W(SPD_W), .BASE_DIV(BASE_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clockwise(clockwise),
    .speed(speed), .mode(mode), .steps(steps),
    .coils(coils), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [3:0]  coils;
    logic        busy;
    logic        done;
    logic [15:0] rem;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: position as plain integer, elapsed cycles since last step.
  int   m_pos, m_elapsed, m_rem, m_mode;
  bit   m_run, m_en, m_cont, m_done;
  exp_t m_prev;

  function automatic logic [3:0] m_pattern(input int p);
    int v;
    v = 1 << (p / 2);
    if (p % 2 == 1) v = v | (1 << (((p + 1) / 2) % PHASES));
    return v[3:0];
  endfunction

  task automatic model_reset();
    m_pos = 0; m_elapsed = 0; m_rem = 0; m_mode = 0;
    m_run = 0; m_en = 0; m_cont = 0; m_done = 0;
    m_prev = '{0, 4'b0, 1'b0, 1'b0, 16'd0};
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cw,
                            input int spd, input int md, input int stp);
    int stride;
    m_done = 0;
    if (!m_run) begin
      if (st && !sp) begin
        m_mode    = (md == 1) ? 1 : (md == 2) ? 2 : 0;
        m_rem     = stp;
        m_cont    = (stp == 0);
        m_elapsed = 0;
        m_en      = 1;
        m_run     = 1;
        if (m_mode == 0) m_pos = m_pos - (m_pos % 2);
        else if (m_mode == 1) m_pos = m_pos - (m_pos % 2) + 1;
      end
    end else if (sp) begin
      m_run = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed >= BASE_DIV * (spd + 1)) begin
        m_elapsed = 0;
        stride = (m_mode == 2) ? 1 : 2;
        m_pos = (m_pos + (cw ? stride : NPOS - stride)) % NPOS;
        if (!m_cont) begin
          m_rem--;
          if (m_rem == 0) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue any expected change.
  task automatic do_cycle(input bit st, input bit sp, input bit cw,
                          input int spd, input int md, input int stp);
    exp_t cur;
    @(negedge clk);
    start = st; stop = sp; clockwise = cw;
    speed = 2'(spd); mode = 2'(md); steps = 16'(stp);
    model_step(st, sp, cw, spd, md, stp);
    cur = '{cyc + 1, m_en ? m_pattern(m_pos) : 4'b0, m_run, m_done, 16'(m_rem)};
    if (cur.coils !== m_prev.coils || cur.busy !== m_prev.busy ||
        cur.done !== m_prev.done || cur.rem !== m_prev.rem) sb.push_back(cur);
    m_prev = cur;
  endtask

  task automatic idle(input int n, input bit cw, input int spd);
    repeat (n) do_cycle(1'b0, 1'b0, cw, spd, 0, 0);
  endtask

  // Monitor
  logic [3:0]  p_coils;
  logic        p_busy, p_done;
  logic [15:0] p_rem;
  exp_t        mon_e;

  always begin
    @(posedge clk);
    #1;
    if (reset !== 1'b1 || !mon_en) begin
      p_coils = coils; p_busy = busy; p_done = done; p_rem = remaining;
    end else begin
      if (coils !== p_coils || busy !== p_busy || done !== p_done || remaining !== p_rem) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: cycle %0d got coils=%b busy=%b done=%b remaining=%0d, required no change",
                   cyc, coils, busy, done, remaining);
        end else begin
          mon_e = sb.pop_front();
          check("event_cycle", cyc, mon_e.cyc);
          check("coils", {28'd0, coils}, {28'd0, mon_e.coils});
          check("busy", {31'd0, busy}, {31'd0, mon_e.busy});
          check("done", {31'd0, done}, {31'd0, mon_e.done});
          check("remaining", {16'd0, remaining}, {16'd0, mon_e.rem});
        end
        p_coils = coils; p_busy = busy; p_done = done; p_rem = remaining;
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_change: required coils=%b busy=%b done=%b remaining=%0d at cycle %0d, got no change by cycle %0d",
                 mon_e.coils, mon_e.busy, mon_e.done, mon_e.rem, mon_e.cyc, cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int spd_r;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clockwise = 1'b1;
    speed = 2'd0; mode = 2'd0; steps = 16'd0;
    model_reset();

    // Asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    check("reset_coils", {28'd0, coils}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_remaining", {16'd0, remaining}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    // Wave, cw, speed 0, 4 steps
    do_cycle(1'b1, 1'b0, 1'b1, 0, 0, 4);
    idle(18, 1'b1, 0);
    check("wave_final_coils", {28'd0, coils}, 32'b0001);
    check("wave_final_busy", {31'd0, busy}, 32'd0);

    // Half, ccw, speed 1, 3 steps from pos 0
    do_cycle(1'b1, 1'b0, 1'b0, 1, 2, 3);
    idle(26, 1'b0, 1);
    check("half_final_coils", {28'd0, coils}, 32'b1100);

    // Reset mid-move at remaining=2
    do_cycle(1'b1, 1'b0, 1'b1, 0, 0, 4);
    idle(8, 1'b1, 0);
    @(posedge clk);
    #3;
    check("pre_reset_remaining", {16'd0, remaining}, 32'd2);
    reset = 1'b0;
    #1;
    check("midreset_coils", {28'd0, coils}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_cycle(1'b1, 1'b0, 1'b1, 0, 0, 4);
    idle(1, 1'b1, 0);
    check("restart_coils", {28'd0, coils}, 32'b0001);
    check("restart_busy", {31'd0, busy}, 32'd1);
    idle(17, 1'b1, 0);

    // Full, cw, continuous, then stop
    do_cycle(1'b1, 1'b0, 1'b1, 0, 1, 0);
    idle(20, 1'b1, 0);
    do_cycle(1'b0, 1'b1, 1'b1, 0, 0, 0);
    idle(1, 1'b1, 0);
    check("stop_hold_coils", {28'd0, coils}, 32'b0110);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_remaining", {16'd0, remaining}, 32'd0);

    // Speed 3 -> 0 at count 9, then start pulse while busy
    do_cycle(1'b1, 1'b0, 1'b1, 3, 0, 5);
    idle(9, 1'b1, 3);
    idle(1, 1'b1, 0);
    do_cycle(1'b1, 1'b0, 1'b1, 0, 2, 9);
    idle(1, 1'b1, 0);
    check("busy_start_remaining", {16'd0, remaining}, 32'd4);
    idle(18, 1'b1, 0);

    // Same-cycle start and stop in IDLE
    do_cycle(1'b1, 1'b1, 1'b1, 0, 0, 3);
    idle(2, 1'b1, 0);
    check("start_stop_idle_busy", {31'd0, busy}, 32'd0);

    // Randomized traffic
    spd_r = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom % 25 == 0) spd_r = int'($urandom % 4);
      do_cycle(($urandom % 8) == 0, ($urandom % 60) == 0, 1'($urandom % 2),
               spd_r, int'($urandom % 4), int'($urandom % 6));
    end
    do_cycle(1'b0, 1'b1, 1'b1, spd_r, 0, 0);
    idle(4, 1'b1, spd_r);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
